// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C/SCCB transaction sequencer: byte command
// encodings, FSM state encoding and the width legality check.
package i2c_pkg;

  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_WRITE = 4'b0010;
  localparam logic [3:0] CMD_READ  = 4'b0100;
  localparam logic [3:0] CMD_STOP  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_STOP,
    ST_WAIT_STOP,
    ST_RSP
  } state_e;

  // Register address and data are each carried as one or two whole bytes.
  function automatic bit widths_legal(input int reg_aw, input int dw);
    return ((reg_aw == 8) || (reg_aw == 16)) && ((dw == 8) || (dw == 16));
  endfunction

endpackage

// File: rtl/i2c_seq_master.sv
// Expands one register read/write into byte requests for the I2C bit engine
// and returns read data plus a NACK status per transaction.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | cmd_rdy high, waiting for a transaction
// REQ        | issue byte idx to the bit engine
// WAIT       | waiting for done of the current byte
// STOP       | issue a bare STOP after a slave NACK
// WAIT_STOP  | waiting for done of the abort STOP
// RSP        | pulse rsp_vld, return to IDLE
module i2c_seq_master
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int         REG_AW   = 16,
  parameter int         DW       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic              cmd_rw,
  input  logic [REG_AW-1:0] cmd_addr,
  input  logic [DW-1:0]     cmd_wdata,
  output logic              req,
  output logic [3:0]        cmd,
  output logic [7:0]        data,
  input  logic              done,
  input  logic              ack_err,
  input  logic [7:0]        rx_data,
  output logic              rsp_vld,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err
);

  localparam int AB   = REG_AW / 8;
  localparam int DB   = DW / 8;
  localparam int N_WR = 1 + AB + DB;
  localparam int N_RD = 2 + AB + DB;
  localparam logic [2:0] LAST_WR = 3'(N_WR - 1);
  localparam logic [2:0] LAST_RD = 3'(N_RD - 1);

  if (!widths_legal(REG_AW, DW)) begin : g_bad_params
    $error("i2c_seq_master: REG_AW and DW must each be 8 or 16");
  end

  state_e            state_q;
  logic [2:0]        idx_q;
  logic              rw_q;
  logic [REG_AW-1:0] addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     acc_q;
  logic              err_q;
  logic              cmd_rdy_q;
  logic              req_q;
  logic [3:0]        cmd_q;
  logic [7:0]        data_q;
  logic              rsp_vld_q;
  logic [DW-1:0]     rsp_rdata_q;
  logic              rsp_err_q;
  logic [11:0]       sel_w;
  logic [2:0]        last_idx;

  // Byte idx of the current transaction as {cmd, data}; multi-byte fields go MSB first.
  function automatic logic [11:0] sel_byte(input logic [2:0] idx, input logic rw,
                                           input logic [REG_AW-1:0] addr,
                                           input logic [DW-1:0] wdata);
    int         i;
    logic [3:0] c;
    logic [7:0] d;
    i = int'(idx);
    c = CMD_WRITE;
    d = 8'h00;
    if (i == 0) begin
      c = CMD_START | CMD_WRITE;
      d = {DEV_ADDR, 1'b0};
    end else if (i <= AB) begin
      d = 8'(addr >> (8 * (AB - i)));
    end else if (!rw) begin
      c = (i == N_WR - 1) ? (CMD_WRITE | CMD_STOP) : CMD_WRITE;
      d = 8'(wdata >> (8 * (N_WR - 1 - i)));
    end else if (i == AB + 1) begin
      c = CMD_START | CMD_WRITE;
      d = {DEV_ADDR, 1'b1};
    end else begin
      c = (i == N_RD - 1) ? (CMD_READ | CMD_STOP) : CMD_READ;
    end
    return {c, d};
  endfunction

  assign sel_w    = sel_byte(idx_q, rw_q, addr_q, wdata_q);
  assign last_idx = rw_q ? LAST_RD : LAST_WR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      cmd_rdy_q   <= 1'b0;
      req_q       <= 1'b0;
      cmd_q       <= '0;
      data_q      <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      req_q     <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_vld && cmd_rdy_q) begin
            cmd_rdy_q <= 1'b0;
            rw_q      <= cmd_rw;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            acc_q     <= '0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            state_q   <= ST_REQ;
          end else begin
            cmd_rdy_q <= 1'b1;
          end
        end
        ST_REQ: begin
          req_q   <= 1'b1;
          cmd_q   <= sel_w[11:8];
          data_q  <= sel_w[7:0];
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done) begin
            if (|(cmd_q & CMD_READ)) begin
              acc_q <= DW'({acc_q, rx_data});
            end
            // A NACKed byte that already carried STOP has closed the bus itself.
            if (ack_err && |(cmd_q & CMD_WRITE)) begin
              err_q   <= 1'b1;
              state_q <= |(cmd_q & CMD_STOP) ? ST_RSP : ST_STOP;
            end else if (idx_q == last_idx) begin
              state_q <= ST_RSP;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= ST_REQ;
            end
          end
        end
        ST_STOP: begin
          req_q   <= 1'b1;
          cmd_q   <= CMD_STOP;
          data_q  <= 8'h00;
          state_q <= ST_WAIT_STOP;
        end
        ST_WAIT_STOP: begin
          if (done) begin
            state_q <= ST_RSP;
          end
        end
        ST_RSP: begin
          rsp_vld_q <= 1'b1;
          rsp_err_q <= err_q;
          if (rw_q && !err_q) begin
            rsp_rdata_q <= acc_q;
          end
          idx_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_rdy   = cmd_rdy_q;
  assign req       = req_q;
  assign cmd       = cmd_q;
  assign data      = data_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_i2c_seq_master.sv
// Directed bench for i2c_seq_master: a 16-bit-address/8-bit-data instance and
// an 8-bit-address/16-bit-data instance driven by one bit-engine responder.
module tb_i2c_seq_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        cmd_vld = 1'b0;
  logic        cmd_rw = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        done = 1'b0;
  logic        ack_err = 1'b0;
  logic [7:0]  rx_data = 8'hFF;

  logic        a_vld, a_done, a_rdy, a_req, a_rsp_vld, a_err;
  logic [3:0]  a_cmd;
  logic [7:0]  a_data, a_rdata;
  logic        b_vld, b_done, b_rdy, b_req, b_rsp_vld, b_err;
  logic [3:0]  b_cmd;
  logic [7:0]  b_data;
  logic [15:0] b_rdata;

  assign a_vld  = cmd_vld & ~sel;
  assign a_done = done & ~sel;
  assign b_vld  = cmd_vld & sel;
  assign b_done = done & sel;

  i2c_seq_master #(.DEV_ADDR(7'h3C), .REG_AW(16), .DW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .cmd_vld(a_vld), .cmd_rdy(a_rdy), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata[7:0]), .req(a_req), .cmd(a_cmd),
    .data(a_data), .done(a_done), .ack_err(ack_err), .rx_data(rx_data),
    .rsp_vld(a_rsp_vld), .rsp_rdata(a_rdata), .rsp_err(a_err));

  i2c_seq_master #(.DEV_ADDR(7'h3C), .REG_AW(8), .DW(16)) u_b (
    .clk(clk), .rst_n(rst_n), .cmd_vld(b_vld), .cmd_rdy(b_rdy), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr[7:0]), .cmd_wdata(cmd_wdata), .req(b_req), .cmd(b_cmd),
    .data(b_data), .done(b_done), .ack_err(ack_err), .rx_data(rx_data),
    .rsp_vld(b_rsp_vld), .rsp_rdata(b_rdata), .rsp_err(b_err));

  logic        rdy_m, req_m, rsp_vld_m, err_m;
  logic [3:0]  cmd_m;
  logic [7:0]  data_m;
  logic [15:0] rdata_m;
  assign rdy_m     = sel ? b_rdy : a_rdy;
  assign req_m     = sel ? b_req : a_req;
  assign rsp_vld_m = sel ? b_rsp_vld : a_rsp_vld;
  assign err_m     = sel ? b_err : a_err;
  assign cmd_m     = sel ? b_cmd : a_cmd;
  assign data_m    = sel ? b_data : a_data;
  assign rdata_m   = sel ? b_rdata : {8'h00, a_rdata};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected bytes are listed first-to-last: cmds one nibble per byte, dats one byte per byte.
  typedef struct {
    logic        sel;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [7:0]  rb0;
    logic [7:0]  rb1;
    int          nack;
    int          n;
    logic [23:0] cmds;
    logic [47:0] dats;
    logic        err;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic s, input logic rw, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [7:0] rb0,
                              input logic [7:0] rb1, input int nack, input int n,
                              input logic [23:0] cmds, input logic [47:0] dats,
                              input logic err, input logic [15:0] rdata);
    vec_t v;
    v.sel = s; v.rw = rw; v.addr = addr; v.wdata = wdata; v.rb0 = rb0; v.rb1 = rb1;
    v.nack = nack; v.n = n; v.cmds = cmds; v.dats = dats; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input bit poke);
    int         k, dly, rd_i, last_done, cyc;
    bit         got;
    logic [3:0] last_cmd;
    k = 0; dly = -1; rd_i = 0; last_done = 0; got = 1'b0; last_cmd = '0;
    sel = v.sel;
    cyc = 0;
    while (rdy_m !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rdy_before_cmd", rdy_m, 1);
    cmd_vld = 1'b1; cmd_rw = v.rw; cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    chk("rdy_drop_on_accept", rdy_m, 0);
    for (cyc = 1; cyc <= 200 && !got; cyc++) begin
      @(posedge clk); #1;
      done = 1'b0; ack_err = 1'b0; rx_data = 8'hFF;
      if (poke && k > 0) begin
        cmd_vld = 1'b1; cmd_rw = ~v.rw; cmd_addr = 16'hDEAD; cmd_wdata = 16'h5A5A;
      end
      if (rsp_vld_m) begin
        cmd_vld = 1'b0;
        got = 1'b1;
        chk("byte_count", k, v.n);
        chk("rsp_err", err_m, v.err);
        chk("rsp_rdata", rdata_m, v.rdata);
        chk("rsp_latency", cyc - last_done, 2);
        chk("rdy_low_at_rsp", rdy_m, 0);
      end else if (req_m) begin
        if (k == 0) chk("first_req_latency", cyc, 1);
        else        chk("req_latency", cyc - last_done, 2);
        if (k < v.n) begin
          chk("byte_cmd", cmd_m, v.cmds[23 - 4*k -: 4]);
          chk("byte_data", data_m, v.dats[47 - 8*k -: 8]);
        end else begin
          chk("extra_byte", k, v.n);
        end
        last_cmd = cmd_m;
        k++;
        dly = 2;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          done = 1'b1;
          ack_err = (k - 1 == v.nack);
          if (last_cmd[2]) begin
            rx_data = (rd_i == 0) ? v.rb0 : v.rb1;
            rd_i++;
          end
          last_done = cyc;
        end
      end
    end
    if (!got) chk("rsp_timeout", got, 1);
    done = 1'b0; ack_err = 1'b0; cmd_vld = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_rsp", rdy_m, 1);
    chk("rsp_vld_one_cycle", rsp_vld_m, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  k, cyc;
    bit  quiet;

    vecs[0] = mk(0, 0, 16'h3008, 16'h0082, 8'h00, 8'h00, -1, 4, 24'h322A00, 48'h7830_0882_0000, 0, 16'h0000);
    vecs[1] = mk(0, 1, 16'h300A, 16'h0000, 8'h56, 8'h00, -1, 5, 24'h3223C0, 48'h7830_0A79_0000, 0, 16'h0056);
    vecs[2] = mk(0, 0, 16'h3008, 16'h0082, 8'h00, 8'h00,  1, 3, 24'h328000, 48'h7830_0000_0000, 1, 16'h0056);
    vecs[3] = mk(0, 1, 16'h300A, 16'h0000, 8'h77, 8'h00,  0, 2, 24'h380000, 48'h7800_0000_0000, 1, 16'h0056);
    vecs[4] = mk(0, 0, 16'h1234, 16'h00A5, 8'h00, 8'h00,  3, 4, 24'h322A00, 48'h7812_34A5_0000, 1, 16'h0056);
    vecs[5] = mk(0, 1, 16'hABCD, 16'h0000, 8'h9E, 8'h00,  4, 5, 24'h3223C0, 48'h78AB_CD79_0000, 0, 16'h009E);
    vecs[6] = mk(0, 1, 16'h300A, 16'h0000, 8'h11, 8'h00,  3, 5, 24'h322380, 48'h7830_0A79_0000, 1, 16'h009E);
    vecs[7] = mk(1, 0, 16'h0012, 16'hBEEF, 8'h00, 8'h00, -1, 4, 24'h322A00, 48'h7812_BEEF_0000, 0, 16'h0000);
    vecs[8] = mk(1, 1, 16'h0034, 16'h0000, 8'hC3, 8'h5A, -1, 5, 24'h3234C0, 48'h7834_7900_0000, 0, 16'hC35A);
    vecs[9] = mk(1, 0, 16'h0056, 16'h0102, 8'h00, 8'h00,  2, 4, 24'h322800, 48'h7856_0100_0000, 1, 16'hC35A);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy_a", a_rdy, 0);
    chk("reset_rdy_b", b_rdy, 0);
    chk("reset_req_a", a_req, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_release", a_rdy, 1);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], i == 0);
    end

    // Reset during WAIT of byte 2 of an A read.
    sel = 1'b0;
    cmd_vld = 1'b1; cmd_rw = 1'b1; cmd_addr = 16'h300A;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    k = 0;
    for (cyc = 0; cyc < 100 && k < 3; cyc++) begin
      @(posedge clk); #1;
      done = 1'b0;
      if (a_req) begin
        k++;
        if (k < 3) begin
          @(posedge clk); #1;
          @(posedge clk); #1;
          done = 1'b1;
        end
      end
    end
    chk("reached_byte2", k, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("mid_reset_rdy", a_rdy, 0);
    chk("mid_reset_req", a_req, 0);
    chk("mid_reset_cmd", a_cmd, 0);
    chk("mid_reset_data", a_data, 0);
    chk("mid_reset_rsp_vld", a_rsp_vld, 0);
    chk("mid_reset_rdata", a_rdata, 0);
    chk("mid_reset_err", a_err, 0);
    chk("mid_reset_rdata_b", b_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_mid_reset", a_rdy, 1);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    quiet = 1'b1;
    repeat (5) begin
      if (a_req || a_rsp_vld || !a_rdy) quiet = 1'b0;
      @(posedge clk); #1;
    end
    chk("stray_done_ignored", quiet, 1);

    run_txn(vecs[0], 0);
    run_txn(vecs[7], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
